// File: rtl/sprite_mask_arbiter_if.sv
// Handshake bundle between the sprite pixel requesters, the shared mask ROM and the arbiter.
// Signal suffixes are named from the arbiter's point of view.
interface sprite_mask_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic                   enable_i;
  logic [NUM_REQ-1:0]     req_i;
  logic [NUM_REQ*8-1:0]   addr_bus_i;
  logic [NUM_REQ-1:0]     grant_o;
  logic [7:0]             rom_addr_o;
  logic                   rom_mask_i;
  logic                   mask_o;
  logic                   mask_valid_o;
  logic [ID_W-1:0]        mask_id_o;
  logic                   busy_o;

  modport slave (
    input  enable_i, req_i, addr_bus_i, rom_mask_i,
    output grant_o, rom_addr_o, mask_o, mask_valid_o, mask_id_o, busy_o
  );

  modport master (
    output enable_i, req_i, addr_bus_i, rom_mask_i,
    input  grant_o, rom_addr_o, mask_o, mask_valid_o, mask_id_o, busy_o
  );
endinterface

// File: rtl/sprite_mask_arbiter.sv
// Round-robin arbiter sharing one 16x16 sprite mask ROM among NUM_REQ requesters, 2-clock lookup.
// Define MASK_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no RR pointer).
module sprite_mask_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sprite_mask_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] eff;
  logic [NUM_REQ-1:0] grant_q;
  logic               found;
  logic               grant_en;
  logic [ID_W-1:0]    win;
  logic [7:0]         sel_addr;
  logic               v1_q;
  logic [ID_W-1:0]    id1_q;
  logic [7:0]         rom_addr_q;
  logic               mask_q;
  logic               mask_valid_q;
  logic [ID_W-1:0]    mask_id_q;
  logic               busy_q;

  // A request is masked in the cycle its grant is visible, before the requester drops it.
  assign eff      = bus.req_i & ~grant_q;
  assign grant_en = found && (state_q == RUN);

`ifdef MASK_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && eff[i]) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    logic [ID_W:0]   j;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    win   = '0;
    j     = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (j >= (ID_W+1)'(NUM_REQ)) j = j - (ID_W+1)'(NUM_REQ);
      idx = j[ID_W-1:0];
      if (!found && eff[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    ptr_d = ptr_q;
    if (grant_en) ptr_d = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    sel_addr = rom_addr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == ID_W'(k)) sel_addr = bus.addr_bus_i[8*k +: 8];
    end
  end

  // DRAIN leaves as soon as stage 1 is empty, so IDLE follows the last valid mask directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable_i) state_d = RUN;
      RUN:     if (!bus.enable_i) state_d = DRAIN;
      DRAIN:   if (bus.enable_i) state_d = RUN;
               else if (!v1_q)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      grant_q      <= '0;
      rom_addr_q   <= 8'h00;
      v1_q         <= 1'b0;
      id1_q        <= '0;
      mask_q       <= 1'b0;
      mask_valid_q <= 1'b0;
      mask_id_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      // Stage 1: grant and ROM address
      grant_q <= grant_en ? (NUM_REQ'(1) << win) : '0;
      v1_q    <= grant_en;
      if (grant_en) begin
        rom_addr_q <= sel_addr;
        id1_q      <= win;
      end
      // Stage 2: capture the ROM's combinational mask bit
      mask_valid_q <= v1_q;
      if (v1_q) begin
        mask_q    <= bus.rom_mask_i;
        mask_id_q <= id1_q;
      end
    end
  end

  assign bus.grant_o      = grant_q;
  assign bus.rom_addr_o   = rom_addr_q;
  assign bus.mask_o       = mask_q;
  assign bus.mask_valid_o = mask_valid_q;
  assign bus.mask_id_o    = mask_id_q;
  assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_sprite_mask_arbiter.sv
// Directed bench for sprite_mask_arbiter with a small mask ROM model on the ROM port.
module tb_sprite_mask_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic rom [256];

  sprite_mask_arbiter_if #(.NUM_REQ(4), .ID_W(2)) ifc ();
  sprite_mask_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;
  assign ifc.rom_mask_i = rom[ifc.rom_addr_o];

  typedef struct {
    logic [3:0] req;
    logic [7:0] addr;
    logic [3:0] exp_grant;
    logic       exp_mask;
    logic [1:0] exp_id;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifc.enable_i = 1'b0;
    ifc.req_i    = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic enter_run();
    ifc.enable_i = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] b2b_grant [6];
    logic [7:0] b2b_addr  [6];
    logic [3:0] alt_grant [6];

    for (int i = 0; i < 256; i++) rom[i] = (i % 8) >= 4;
    rom[8'h00] = 1'b1;
    rom[8'h03] = 1'b0;
    rom[8'h0d] = 1'b1;
    rom[8'h3f] = 1'b0;
    rom[8'hff] = 1'b1;

    tbl[0] = '{4'b0001, 8'h00, 4'b0001, 1'b1, 2'd0};
    tbl[1] = '{4'b0010, 8'h0d, 4'b0010, 1'b1, 2'd1};
    tbl[2] = '{4'b0100, 8'h3f, 4'b0100, 1'b0, 2'd2};
    tbl[3] = '{4'b1000, 8'hff, 4'b1000, 1'b1, 2'd3};
    tbl[4] = '{4'b0010, 8'h03, 4'b0010, 1'b0, 2'd1};
    tbl[5] = '{4'b0100, 8'h44, 4'b0100, 1'b1, 2'd2};
    tbl[6] = '{4'b1000, 8'h10, 4'b1000, 1'b0, 2'd3};

    b2b_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    b2b_addr  = '{8'h03, 8'h0d, 8'h3f, 8'hff, 8'hff, 8'hff};
    alt_grant = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};

    ifc.enable_i   = 1'b0;
    ifc.req_i      = 4'b0000;
    ifc.addr_bus_i = '0;

    // Reset values
    #3;
    chk("rst_grant", 32'(ifc.grant_o), 32'h0);
    chk("rst_addr",  32'(ifc.rom_addr_o), 32'h0);
    chk("rst_mask",  32'(ifc.mask_o), 32'h0);
    chk("rst_valid", 32'(ifc.mask_valid_o), 32'h0);
    chk("rst_id",    32'(ifc.mask_id_o), 32'h0);
    chk("rst_busy",  32'(ifc.busy_o), 32'h0);
    do_reset();

    // Four simultaneous requests served back to back from pointer 0
    ifc.addr_bus_i = {8'hff, 8'h3f, 8'h0d, 8'h03};
    enter_run();
    chk("run_busy", 32'(ifc.busy_o), 32'h1);
    ifc.req_i = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("b2b_grant%0d", c), 32'(ifc.grant_o), 32'(b2b_grant[c]));
      chk($sformatf("b2b_addr%0d", c), 32'(ifc.rom_addr_o), 32'(b2b_addr[c]));
      if (c >= 1 && c <= 4) begin
        chk($sformatf("b2b_valid%0d", c), 32'(ifc.mask_valid_o), 32'h1);
        chk($sformatf("b2b_id%0d", c), 32'(ifc.mask_id_o), 32'(c - 1));
        chk($sformatf("b2b_mask%0d", c), 32'(ifc.mask_o), 32'((c - 1) % 2));
      end else if (c == 5) begin
        chk("b2b_valid_end", 32'(ifc.mask_valid_o), 32'h0);
      end
      ifc.req_i = ifc.req_i & ~ifc.grant_o;
    end

    // Table: single lookups, grant at t+1 and mask at t+2; other lanes hold decoys
    for (int v = 0; v < 7; v++) begin
      ifc.addr_bus_i = {4{8'ha5}};
      ifc.addr_bus_i[8*tbl[v].exp_id +: 8] = tbl[v].addr;
      ifc.req_i = tbl[v].req;
      tick();
      chk($sformatf("tbl%0d_grant", v), 32'(ifc.grant_o), 32'(tbl[v].exp_grant));
      chk($sformatf("tbl%0d_addr", v), 32'(ifc.rom_addr_o), 32'(tbl[v].addr));
      ifc.req_i = 4'b0000;
      tick();
      chk($sformatf("tbl%0d_valid", v), 32'(ifc.mask_valid_o), 32'h1);
      chk($sformatf("tbl%0d_mask", v), 32'(ifc.mask_o), 32'(tbl[v].exp_mask));
      chk($sformatf("tbl%0d_id", v), 32'(ifc.mask_id_o), 32'(tbl[v].exp_id));
      chk($sformatf("tbl%0d_nogrant", v), 32'(ifc.grant_o), 32'h0);
      chk($sformatf("tbl%0d_addrhold", v), 32'(ifc.rom_addr_o), 32'(tbl[v].addr));
    end
    tick();
    chk("tbl_idle_valid", 32'(ifc.mask_valid_o), 32'h0);

    // Requesters 0 and 2 both request continuously: grants alternate
    do_reset();
    ifc.addr_bus_i = {8'hff, 8'h3f, 8'h0d, 8'h00};
    enter_run();
    ifc.req_i = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("alt_grant%0d", c), 32'(ifc.grant_o), 32'(alt_grant[c]));
    end
    ifc.req_i = 4'b0000;

    // Enable dropped the cycle after a grant: one more mask, then idle
    do_reset();
    enter_run();
    ifc.req_i = 4'b0010;
    tick();
    chk("drain_grant", 32'(ifc.grant_o), 32'b0010);
    ifc.req_i    = 4'b0000;
    ifc.enable_i = 1'b0;
    tick();
    chk("drain_valid", 32'(ifc.mask_valid_o), 32'h1);
    chk("drain_id",    32'(ifc.mask_id_o), 32'h1);
    chk("drain_busy",  32'(ifc.busy_o), 32'h1);
    chk("drain_nogrant", 32'(ifc.grant_o), 32'h0);
    tick();
    chk("drain_end_valid", 32'(ifc.mask_valid_o), 32'h0);
    chk("drain_end_busy",  32'(ifc.busy_o), 32'h0);

    // Request held through IDLE is served one cycle after RUN entry
    ifc.req_i = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("idle_nogrant%0d", c), 32'(ifc.grant_o), 32'h0);
      chk($sformatf("idle_busy%0d", c), 32'(ifc.busy_o), 32'h0);
    end
    ifc.enable_i = 1'b1;
    tick();
    chk("entry_busy", 32'(ifc.busy_o), 32'h1);
    chk("entry_nogrant", 32'(ifc.grant_o), 32'h0);
    tick();
    chk("entry_grant", 32'(ifc.grant_o), 32'b0100);
    chk("entry_addr", 32'(ifc.rom_addr_o), 32'h3f);
    ifc.req_i = 4'b0000;
    tick();
    chk("entry_valid", 32'(ifc.mask_valid_o), 32'h1);
    chk("entry_mask",  32'(ifc.mask_o), 32'h0);
    chk("entry_id",    32'(ifc.mask_id_o), 32'h2);

    // Asynchronous reset with lookups in flight
    do_reset();
    ifc.addr_bus_i = {8'hff, 8'h3f, 8'h0d, 8'h03};
    enter_run();
    ifc.req_i = 4'b1111;
    tick();
    ifc.req_i = ifc.req_i & ~ifc.grant_o;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", 32'(ifc.grant_o), 32'h0);
    chk("arst_addr",  32'(ifc.rom_addr_o), 32'h0);
    chk("arst_mask",  32'(ifc.mask_o), 32'h0);
    chk("arst_valid", 32'(ifc.mask_valid_o), 32'h0);
    chk("arst_id",    32'(ifc.mask_id_o), 32'h0);
    chk("arst_busy",  32'(ifc.busy_o), 32'h0);
    ifc.req_i    = 4'b0000;
    ifc.enable_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("arst_stale%0d", c), 32'(ifc.mask_valid_o), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
